// File: rtl/traffic_phase_ctrl.sv
// N-approach adaptive signal controller: density-scaled greens, demand-skipping
// round-robin, yellow/all-red clearance and emergency preemption.
module traffic_phase_ctrl #(
  parameter int N_APPR     = 4,
  parameter int IDX_W      = 2,
  parameter int SENS_W     = 2,
  parameter int MIN_GREEN  = 4,
  parameter int GREEN_STEP = 2,
  parameter int YELLOW_T   = 3,
  parameter int ALLRED_T   = 2,
  parameter int CNT_W      = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_APPR*SENS_W-1:0] sensor,
  input  logic [N_APPR-1:0]        emerg_req,
  output logic [N_APPR-1:0]        green,
  output logic [N_APPR-1:0]        yellow,
  output logic [N_APPR-1:0]        red,
  output logic [IDX_W-1:0]         active_idx,
  output logic                     emerg_active
);
  typedef enum logic [1:0] {ST_ALLRED, ST_GREEN, ST_YELLOW} state_t;

  state_t            state;
  logic [CNT_W-1:0]  timer;
  logic              pend_vld;
  logic [IDX_W-1:0]  pend_idx;

  logic              emerg_any, emerg_other, emerg_self, other_demand, sel_emerg;
  logic [IDX_W-1:0]  emerg_low, emerg_other_low, rr_idx, sel_idx;
  logic [CNT_W-1:0]  sel_time, dwell_time;
  logic [N_APPR-1:0] sel_oh, act_oh;

  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int k);
    return IDX_W'((int'(base) + k) % N_APPR);
  endfunction

  function automatic logic [SENS_W-1:0] sens_of(input logic [N_APPR*SENS_W-1:0] s,
                                                input logic [IDX_W-1:0] idx);
    return s[int'(idx)*SENS_W +: SENS_W];
  endfunction

  function automatic logic [CNT_W-1:0] green_time(input logic [SENS_W-1:0] d);
    return CNT_W'(MIN_GREEN) + CNT_W'(d) * CNT_W'(GREEN_STEP);
  endfunction

  always_comb begin
    emerg_low       = '0;
    emerg_other_low = '0;
    emerg_other     = 1'b0;
    other_demand    = 1'b0;
    rr_idx          = wrap_idx(active_idx, 1);
    act_oh          = {{(N_APPR-1){1'b0}}, 1'b1} << active_idx;
    emerg_any       = |emerg_req;
    emerg_self      = |(emerg_req & act_oh);
    // Descending scans so the lowest index / nearest successor is written last.
    for (int i = N_APPR-1; i >= 0; i--) begin
      if (emerg_req[i]) emerg_low = IDX_W'(i);
      if (emerg_req[i] && IDX_W'(i) != active_idx) begin
        emerg_other     = 1'b1;
        emerg_other_low = IDX_W'(i);
      end
      if (sensor[i*SENS_W +: SENS_W] != '0 && IDX_W'(i) != active_idx) other_demand = 1'b1;
    end
    for (int k = N_APPR; k >= 1; k--) begin
      if (sens_of(sensor, wrap_idx(active_idx, k)) != '0) rr_idx = wrap_idx(active_idx, k);
    end
    // A pulse that truncated a green is remembered until the next grant.
    if (emerg_any) begin
      sel_idx   = emerg_low;
      sel_emerg = 1'b1;
    end else if (pend_vld) begin
      sel_idx   = pend_idx;
      sel_emerg = 1'b1;
    end else begin
      sel_idx   = rr_idx;
      sel_emerg = 1'b0;
    end
    sel_time   = sel_emerg ? CNT_W'(MIN_GREEN) : green_time(sens_of(sensor, sel_idx));
    sel_oh     = {{(N_APPR-1){1'b0}}, 1'b1} << sel_idx;
    dwell_time = green_time(sens_of(sensor, active_idx));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_ALLRED;
      timer        <= CNT_W'(ALLRED_T);
      green        <= '0;
      yellow       <= '0;
      red          <= '1;
      active_idx   <= IDX_W'(N_APPR-1);
      emerg_active <= 1'b0;
      pend_vld     <= 1'b0;
      pend_idx     <= '0;
    end else begin
      case (state)
        ST_ALLRED: begin
          if (timer > CNT_W'(1)) begin
            timer <= timer - CNT_W'(1);
          end else begin
            state        <= ST_GREEN;
            timer        <= sel_time;
            active_idx   <= sel_idx;
            emerg_active <= sel_emerg;
            pend_vld     <= 1'b0;
            green        <= sel_oh;
            red          <= ~sel_oh;
          end
        end
        ST_GREEN: begin
          if (emerg_active) begin
            if (timer > CNT_W'(1)) begin
              timer <= timer - CNT_W'(1);
            end else if (!emerg_self) begin
              state  <= ST_YELLOW;
              timer  <= CNT_W'(YELLOW_T);
              green  <= '0;
              yellow <= act_oh;
            end
          end else if (emerg_other) begin
            state    <= ST_YELLOW;
            timer    <= CNT_W'(YELLOW_T);
            green    <= '0;
            yellow   <= act_oh;
            pend_vld <= 1'b1;
            pend_idx <= emerg_other_low;
          end else if (!emerg_self) begin
            if (timer > CNT_W'(1)) begin
              timer <= timer - CNT_W'(1);
            end else if (other_demand) begin
              state  <= ST_YELLOW;
              timer  <= CNT_W'(YELLOW_T);
              green  <= '0;
              yellow <= act_oh;
            end else begin
              timer <= dwell_time;
            end
          end
        end
        ST_YELLOW: begin
          if (timer > CNT_W'(1)) begin
            timer <= timer - CNT_W'(1);
          end else begin
            state  <= ST_ALLRED;
            timer  <= CNT_W'(ALLRED_T);
            yellow <= '0;
            red    <= '1;
          end
        end
        default: begin
          state  <= ST_ALLRED;
          timer  <= CNT_W'(ALLRED_T);
          green  <= '0;
          yellow <= '0;
          red    <= '1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl at default parameters; phase lengths
// are measured on the lamps at the falling edge.
module tb_traffic_phase_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] sensor = '0;
  logic [3:0] emerg_req = '0;
  logic [3:0] green, yellow, red;
  logic [1:0] active_idx;
  logic       emerg_active;

  int checks = 0;
  int errors = 0;

  traffic_phase_ctrl #(
    .N_APPR(4), .IDX_W(2), .SENS_W(2), .MIN_GREEN(4), .GREEN_STEP(2),
    .YELLOW_T(3), .ALLRED_T(2), .CNT_W(8)
  ) dut (
    .clk(clk), .reset(reset), .sensor(sensor), .emerg_req(emerg_req),
    .green(green), .yellow(yellow), .red(red),
    .active_idx(active_idx), .emerg_active(emerg_active)
  );

  always #5 clk = ~clk;

  // kind: 0 = green[idx], 1 = yellow[idx], 2 = all approaches red
  function automatic logic lamp_on(input int kind, input int idx);
    case (kind)
      0:       return green[idx];
      1:       return yellow[idx];
      default: return red == 4'b1111;
    endcase
  endfunction

  function automatic logic lamps_clean();
    int nonred = 0;
    for (int i = 0; i < 4; i++) begin
      if (int'(green[i]) + int'(yellow[i]) + int'(red[i]) != 1) return 1'b0;
      if (!red[i]) nonred++;
    end
    return nonred <= 1;
  endfunction

  task automatic run_len(input int kind, input int idx, output int len, output logic clean);
    len = 0;
    clean = 1'b1;
    while (lamp_on(kind, idx) && len < 200) begin
      if (!lamps_clean()) clean = 1'b0;
      len++;
      @(negedge clk);
    end
  endtask

  task automatic wait_lamp(input int kind, input int idx, output logic ok);
    int n = 0;
    while (!lamp_on(kind, idx) && n < 100) begin
      @(negedge clk);
      n++;
    end
    ok = lamp_on(kind, idx);
  endtask

  task automatic do_reset(input logic [7:0] s);
    sensor = s;
    emerg_req = '0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    int len, bad;
    logic cl;
    sensor = '0;
    emerg_req = '0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (red !== 4'b1111) begin errors++; $display("FAIL rst_red: got %b want 1111", red); end
    checks++; if (green !== 4'b0000 || yellow !== 4'b0000) begin errors++; $display("FAIL rst_gy: got g=%b y=%b want 0000", green, yellow); end
    checks++; if (active_idx !== 2'd3) begin errors++; $display("FAIL rst_idx: got %0d want 3", active_idx); end
    checks++; if (emerg_active !== 1'b0) begin errors++; $display("FAIL rst_emerg: got %b want 0", emerg_active); end
    reset = 1'b1;
    @(negedge clk);
    run_len(2, 0, len, cl);
    checks++; if (len !== 2) begin errors++; $display("FAIL rst_allred_len: got %0d want 2", len); end
    checks++; if (green !== 4'b0001 || active_idx !== 2'd0) begin errors++; $display("FAIL rst_first_green: got g=%b idx=%0d want 0001 idx=0", green, active_idx); end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (green !== 4'b0001 || yellow !== 4'b0000 || active_idx !== 2'd0) bad++;
      @(negedge clk);
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL dwell_no_yellow: got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_skip();
    int len;
    logic cl, cl_all;
    cl_all = 1'b1;
    do_reset(8'b00_01_00_11);
    run_len(2, 0, len, cl); cl_all &= cl;
    checks++; if (len !== 2) begin errors++; $display("FAIL skip_allred0: got %0d want 2", len); end
    run_len(0, 0, len, cl); cl_all &= cl;
    checks++; if (len !== 10) begin errors++; $display("FAIL skip_green0: got %0d want 10", len); end
    run_len(1, 0, len, cl); cl_all &= cl;
    checks++; if (len !== 3) begin errors++; $display("FAIL skip_yellow0: got %0d want 3", len); end
    run_len(2, 0, len, cl); cl_all &= cl;
    checks++; if (len !== 2) begin errors++; $display("FAIL skip_allred1: got %0d want 2", len); end
    checks++; if (green !== 4'b0100 || active_idx !== 2'd2) begin errors++; $display("FAIL skip_to_2: got g=%b idx=%0d want 0100 idx=2", green, active_idx); end
    sensor[5:4] = 2'd3;
    run_len(0, 2, len, cl); cl_all &= cl;
    checks++; if (len !== 6) begin errors++; $display("FAIL skip_green2_latched: got %0d want 6", len); end
    run_len(1, 2, len, cl); cl_all &= cl;
    checks++; if (len !== 3) begin errors++; $display("FAIL skip_yellow2: got %0d want 3", len); end
    run_len(2, 0, len, cl); cl_all &= cl;
    checks++; if (len !== 2) begin errors++; $display("FAIL skip_allred2: got %0d want 2", len); end
    checks++; if (green !== 4'b0001 || active_idx !== 2'd0) begin errors++; $display("FAIL skip_back_to_0: got g=%b idx=%0d want 0001 idx=0", green, active_idx); end
    checks++; if (cl_all !== 1'b1) begin errors++; $display("FAIL skip_lamp_exclusive: got %b want 1", cl_all); end
  endtask

  task automatic test_round_robin();
    int len, bad;
    logic cl, cl_all;
    cl_all = 1'b1;
    bad = 0;
    do_reset(8'hAA);
    run_len(2, 0, len, cl);
    for (int k = 0; k < 4; k++) begin
      checks++; if (green[k] !== 1'b1 || active_idx !== 2'(k)) begin errors++; $display("FAIL rr_select_%0d: got g=%b idx=%0d want idx=%0d", k, green, active_idx, k); end
      run_len(0, k, len, cl); cl_all &= cl;
      checks++; if (len !== 8) begin errors++; $display("FAIL rr_green_%0d: got %0d want 8", k, len); end
      run_len(1, k, len, cl); cl_all &= cl;
      if (len !== 3) bad++;
      run_len(2, 0, len, cl); cl_all &= cl;
      if (len !== 2) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL rr_clearance: got %0d wrong clearances want 0", bad); end
    checks++; if (green !== 4'b0001 || active_idx !== 2'd0) begin errors++; $display("FAIL rr_wrap: got g=%b idx=%0d want 0001 idx=0", green, active_idx); end
    checks++; if (cl_all !== 1'b1) begin errors++; $display("FAIL rr_lamp_exclusive: got %b want 1", cl_all); end
  endtask

  task automatic test_emerg_pulse();
    int len;
    logic cl;
    do_reset(8'h00);
    run_len(2, 0, len, cl);
    @(negedge clk);
    emerg_req = 4'b1000;
    @(negedge clk);
    emerg_req = 4'b0000;
    checks++; if (yellow !== 4'b0001) begin errors++; $display("FAIL ep_truncate: got y=%b want 0001", yellow); end
    run_len(1, 0, len, cl);
    checks++; if (len !== 3) begin errors++; $display("FAIL ep_yellow0: got %0d want 3", len); end
    run_len(2, 0, len, cl);
    checks++; if (len !== 2) begin errors++; $display("FAIL ep_allred: got %0d want 2", len); end
    checks++; if (green !== 4'b1000 || active_idx !== 2'd3 || emerg_active !== 1'b1) begin errors++; $display("FAIL ep_grant3: got g=%b idx=%0d em=%b want 1000 idx=3 em=1", green, active_idx, emerg_active); end
    run_len(0, 3, len, cl);
    checks++; if (len !== 4) begin errors++; $display("FAIL ep_green3: got %0d want 4", len); end
    run_len(1, 3, len, cl);
    run_len(2, 0, len, cl);
    checks++; if (green !== 4'b0001 || active_idx !== 2'd0 || emerg_active !== 1'b0) begin errors++; $display("FAIL ep_resume: got g=%b idx=%0d em=%b want 0001 idx=0 em=0", green, active_idx, emerg_active); end
  endtask

  task automatic test_emerg_hold();
    int len, cnt, bad;
    logic cl, ok;
    do_reset(8'h00);
    run_len(2, 0, len, cl);
    emerg_req = 4'b0010;
    wait_lamp(0, 1, ok);
    checks++; if (ok !== 1'b1 || emerg_active !== 1'b1) begin errors++; $display("FAIL eh_grant1: got ok=%b em=%b want 1 1", ok, emerg_active); end
    cnt = 0;
    bad = 0;
    while (green[1] && cnt < 60) begin
      if (red !== 4'b1101 || emerg_active !== 1'b1) bad++;
      cnt++;
      if (cnt == 20) emerg_req = 4'b0000;
      @(negedge clk);
    end
    emerg_req = 4'b0000;
    checks++; if (cnt !== 20) begin errors++; $display("FAIL eh_green_len: got %0d want 20", cnt); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL eh_others_red: got %0d bad cycles want 0", bad); end
    checks++; if (yellow !== 4'b0010) begin errors++; $display("FAIL eh_release_yellow: got y=%b want 0010", yellow); end
  endtask

  task automatic test_simultaneous();
    int len;
    logic cl, ok;
    do_reset(8'h00);
    run_len(2, 0, len, cl);
    emerg_req = 4'b1100;
    wait_lamp(0, 2, ok);
    checks++; if (ok !== 1'b1 || active_idx !== 2'd2 || green[3] !== 1'b0) begin errors++; $display("FAIL simul_lowest: got ok=%b idx=%0d g=%b want idx=2 g=0100", ok, active_idx, green); end
    emerg_req = 4'b0000;
  endtask

  task automatic test_reset_mid();
    int len;
    logic cl, ok;
    do_reset(8'b00_00_01_01);
    run_len(2, 0, len, cl);
    wait_lamp(1, 0, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rm_reach_yellow: got %b want 1", ok); end
    #2 reset = 1'b0;
    #1;
    checks++; if (red !== 4'b1111 || yellow !== 4'b0000 || green !== 4'b0000) begin errors++; $display("FAIL rm_async_red: got r=%b y=%b g=%b want 1111 0000 0000", red, yellow, green); end
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    run_len(2, 0, len, cl);
    checks++; if (len !== 2) begin errors++; $display("FAIL rm_allred_len: got %0d want 2", len); end
    checks++; if (green !== 4'b0001 || active_idx !== 2'd0) begin errors++; $display("FAIL rm_restart: got g=%b idx=%0d want 0001 idx=0", green, active_idx); end
  endtask

  initial begin
    test_reset();
    test_skip();
    test_round_robin();
    test_emerg_pulse();
    test_emerg_hold();
    test_simultaneous();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
